random_lfsr: RTL and testbench

Free-running 16-bit pseudo-random number source built on a maximal-length Fibonacci LFSR. It advances one step on every clock edge and exposes its full state as a registered output. Game/graphics logic instantiates it wherever random bits are needed, e.g. road-segment length, road direction and curve-parameter selection. Every instance with the same SEED produces the identical sequence after reset.

---
 rtl/random_pkg.sv | 16 +
 rtl/random_lfsr.sv | 54 +++++
 tb/tb_random_lfsr.sv | 121 ++++++++++++
 3 files changed

// File: rtl/random_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR random source.
package random_pkg;

  localparam int LFSR_W = 16;

  typedef logic [LFSR_W-1:0] lfsr_t;

  localparam lfsr_t LFSR_SEED_DEFAULT = 16'hACE1;
  localparam lfsr_t LFSR_TAPS_16      = 16'h002D;

  // Right shift with the XOR of the tapped bits entering at the MSB.
  function automatic lfsr_t lfsr_next(lfsr_t s, lfsr_t taps);
    return {^(s & taps), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/random_lfsr.sv
// Free-running 16-bit maximal-length Fibonacci LFSR; output is the registered state.
// Optional lock-up recovery from the all-zero state: define RANDOM_LFSR_LOCKUP_GUARD_EN.
module random_lfsr
  import random_pkg::*;
#(
  parameter int    WIDTH = LFSR_W,
  parameter lfsr_t SEED  = LFSR_SEED_DEFAULT,
  parameter lfsr_t TAPS  = LFSR_TAPS_16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] random
);

  if (WIDTH != LFSR_W) begin : g_width_check
    $error("random_lfsr: only WIDTH=16 is supported");
  end

`ifndef RANDOM_LFSR_LOCKUP_GUARD_EN
  if (SEED == '0) begin : g_seed_check
    $error("random_lfsr: SEED must be non-zero (all-zero state is a fixed point)");
  end
`endif

  lfsr_t state;
  lfsr_t next_state;

`ifdef RANDOM_LFSR_LOCKUP_GUARD_EN
  // A zero seed cannot be used as the recovery value, so fall back to 1.
  localparam lfsr_t GUARD_RELOAD = (SEED == '0) ? lfsr_t'(1) : SEED;
`endif

  // NOTE: assign a default first so every path writes next_state and no latch is inferred.
  always_comb begin
    next_state = lfsr_next(state, TAPS);
`ifdef RANDOM_LFSR_LOCKUP_GUARD_EN
    if (state == '0) begin
      next_state = GUARD_RELOAD;
    end
`endif
  end

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= next_state;
    end
  end

  assign random = state;

endmodule

// File: tb/tb_random_lfsr.sv
// Self-checking bench for random_lfsr against an arithmetic reference of the LFSR rule.
module tb_random_lfsr;
  import random_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] random_a;
  logic [15:0] random_b;
  logic [15:0] random_s1;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  random_lfsr dut_a (.clk(clk), .rst(rst), .random(random_a));
  random_lfsr dut_b (.clk(clk), .rst(rst), .random(random_b));
  random_lfsr #(.SEED(16'h0001)) dut_s1 (.clk(clk), .rst(rst), .random(random_s1));

`ifdef RANDOM_LFSR_LOCKUP_GUARD_EN
  logic [15:0] random_z;
  random_lfsr #(.SEED(16'h0000)) dut_z (.clk(clk), .rst(rst), .random(random_z));
  int unsigned exp_z;
`endif

  int unsigned exp_a;
  int unsigned exp_s1;

  bit seen [65536];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1: feedback is the parity of bits 0,2,3,5.
  function automatic int unsigned ref_step(int unsigned s);
    int unsigned fb;
    fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
    return ((s >> 1) | (fb << 15)) & 16'hFFFF;
  endfunction

  // Drive rst, advance one clock, update the models, then compare on the falling edge.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    exp_a  = r ? 32'hACE1 : ref_step(exp_a);
    exp_s1 = r ? 32'h0001 : ref_step(exp_s1);
`ifdef RANDOM_LFSR_LOCKUP_GUARD_EN
    exp_z  = r ? 0 : ((exp_z == 0) ? 1 : ref_step(exp_z));
`endif
    @(negedge clk);
    check("dut_a", random_a, 16'(exp_a));
    check("dut_b", random_b, 16'(exp_a));
    check("dut_s1", random_s1, 16'(exp_s1));
`ifdef RANDOM_LFSR_LOCKUP_GUARD_EN
    check("dut_z", random_z, 16'(exp_z));
`endif
  endtask

  initial begin
    int dup_count;
    int zero_count;
    logic [15:0] s;

    rst        = 1'b1;
    exp_a      = 0;
    exp_s1     = 0;
`ifdef RANDOM_LFSR_LOCKUP_GUARD_EN
    exp_z      = 0;
`endif
    dup_count  = 0;
    zero_count = 0;

    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("reset_hold", random_a, 16'hACE1);
    end

    seen[random_a] = 1'b1;
    for (int k = 1; k <= 65535; k++) begin
      step(1'b0);
      if (k == 1) check("first_step", random_a, 16'h5670);
      if (k == 2) check("second_step", random_a, 16'hAB38);
`ifdef RANDOM_LFSR_LOCKUP_GUARD_EN
      if (k == 1) check("guard_reload", random_z, 16'h0001);
`endif
      if (k < 65535) begin
        if (random_a == 16'h0000) zero_count++;
        if (seen[random_a]) dup_count++;
        seen[random_a] = 1'b1;
      end
    end
    check("wrap_to_seed", random_a, 16'hACE1);
    check("period_zero_count", 16'(zero_count), 16'd0);
    check("period_dup_count", 16'(dup_count), 16'd0);

    for (int i = 0; i < 100; i++) step(1'b0);
    step(1'b1);
    check("midrun_reset", random_a, 16'hACE1);
    step(1'b0);
    check("after_midrun_reset", random_a, 16'h5670);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      s = 16'($urandom_range(1, 65535));
      check("pkg_lfsr_next", lfsr_next(s, LFSR_TAPS_16), 16'(ref_step(32'(s))));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
